multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle sequencer for the MIPS-subset core: replaces the single-cycle opcode decoder with a Moore FSM that drives the shared datapath (one memory port, one ALU, PC/IR/A/B/ALUOut registers) across several cycles per instruction. Supports R-type, LW, SW, BEQ, ADDI and J. Inserts wait states on a memory-ready handshake. Sits between the instruction register opcode field and every datapath enable/mux select.

## Interface
- No parameters; opcode, state and ALU-op encodings come from the shared package.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- opcode_input  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- mem_read  out  1  memory read request
- memory_write  out  1  memory write request
- iord  out  1  address mux: 0 = PC, 1 = ALUOut
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC load
- branch_control  out  1  conditional PC load (datapath ANDs with ALU zero)
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- alu_operation  out  2  00 add, 01 subtract, 10 funct-field decode
- register_write  out  1  register file write
- register_destination  out  1  0 = rt, 1 = rd
- memory_to_register  out  1  0 = ALUOut, 1 = MDR
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- illegal_opcode  out  1  one-cycle pulse when DECODE sees an unsupported opcode

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP.
- Outputs are a pure function of state (plus mem_ready gating below). Any output not listed for a state is 0.
- IDLE: all outputs 0. Unconditionally goes to FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_operation=00, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_operation=00 (branch target into ALUOut). Next state by opcode:
  - 000000 → R_EXEC
  - 100011 or 101011 → MEM_ADDR
  - 001000 → ADDI_EXEC
  - 000100 → BRANCH
  - 000010 → JUMP
  - any other opcode → FETCH, with illegal_opcode=1.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_operation=00. Goes to MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: mem_read=1, iord=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: register_write=1, register_destination=0, memory_to_register=1, instr_done=1. Goes to FETCH.
- MEM_WRITE: memory_write=1, iord=1. instr_done equals mem_ready. Waits for mem_ready, then goes to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_operation=10. Goes to R_WB.
- R_WB: register_write=1, register_destination=1, memory_to_register=0, instr_done=1. Goes to FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_operation=00. Goes to ADDI_WB.
- ADDI_WB: register_write=1, register_destination=0, memory_to_register=0, instr_done=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_operation=01, branch_control=1, pc_source=01, instr_done=1. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Goes to FETCH.
- Opcode is sampled only in DECODE and MEM_ADDR; changes at other times are ignored.

## Timing
- Reset: asynchronous entry to IDLE; every output reads 0 while reset_n=0 and in the first cycle after release.
- Cycles per instruction with mem_ready held high: R 4, LW 5, SW 4, ADDI 4, BEQ 3, J 3, illegal 2.
- Each low cycle of mem_ready in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- No output toggles while waiting, except the gated pulses, which stay 0.
- Reset asserted mid-instruction aborts it immediately with no further write enables. Execution restarts IDLE → FETCH.
- Exactly one instr_done pulse per completed instruction. None for an illegal opcode.

## Structure
- Shared package holds:
  - state enum (4-bit encoding)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J
  - ALU-op constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - alu_src_b and pc_source select constants
- Top level holds the state register and next-state logic.
- One combinational sub-module, multicycle_control_outputs, maps state plus mem_ready to all control outputs.

## Test plan
- Reset, then R-type (000000) with mem_ready=1 → states IDLE, FETCH, DECODE, R_EXEC, R_WB. In R_WB: register_write=1, register_destination=1; instr_done high on cycle 5 after reset release.
- LW (100011) with mem_ready low 2 cycles in MEM_READ → MEM_READ lasts 3 cycles, iord=1 throughout. MEM_WB: memory_to_register=1. LW totals 7 cycles.
- SW (101011) with mem_ready=1 → memory_write=1 for one cycle, register_write never asserted, back in FETCH after 4 cycles.
- BEQ (000100) then J (000010) → BRANCH: branch_control=1, alu_operation=01, pc_source=01. JUMP: pc_write=1, pc_source=10. 3 cycles each.
- Opcode 111111 in DECODE → illegal_opcode pulse, no write enables, FETCH the next cycle, no instr_done.
- reset_n dropped in MEM_WRITE while mem_ready=0 → all outputs 0 asynchronously; IDLE then FETCH after release.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_pkg
// Brief    : Shared encodings for the multicycle sequencer: FSM states,
//            opcodes, ALU-op codes and datapath mux selects.
// Revision : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_R_EXEC    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_ADDI_EXEC = 4'd9,
    ST_ADDI_WB   = 4'd10,
    ST_BRANCH    = 4'd11,
    ST_JUMP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_REG_B   = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // State that follows DECODE for a given opcode; unsupported codes refetch.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:     return ST_R_EXEC;
      OP_LW, OP_SW: return ST_MEM_ADDR;
      OP_ADDI:      return ST_ADDI_EXEC;
      OP_BEQ:       return ST_BRANCH;
      OP_J:         return ST_JUMP;
      default:      return ST_FETCH;
    endcase
  endfunction

  function automatic logic is_supported(input logic [5:0] op);
    return (decode_next(op) != ST_FETCH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_if
// Brief    : Bundle between the sequencer (master) and the shared datapath
//            (slave): opcode/handshake in, every enable and mux select out.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_if;
  logic [5:0] opcode_input;
  logic       mem_ready;
  logic       mem_read;
  logic       memory_write;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       branch_control;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_operation;
  logic       register_write;
  logic       register_destination;
  logic       memory_to_register;
  logic       instr_done;
  logic       illegal_opcode;

  modport master (
    input  opcode_input, mem_ready,
    output mem_read, memory_write, iord, ir_write, pc_write, branch_control,
           pc_source, alu_src_a, alu_src_b, alu_operation, register_write,
           register_destination, memory_to_register, instr_done, illegal_opcode
  );

  modport slave (
    output opcode_input, mem_ready,
    input  mem_read, memory_write, iord, ir_write, pc_write, branch_control,
           pc_source, alu_src_a, alu_src_b, alu_operation, register_write,
           register_destination, memory_to_register, instr_done, illegal_opcode
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_outputs.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_outputs
// Brief    : Combinational decode of the current state into datapath
//            controls. Only the FETCH/MEM_WRITE pulses look at mem_ready, and
//            only DECODE looks at the opcode (to flag unsupported codes).
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_outputs
  import multicycle_control_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic [5:0] opcode_input,
  output logic       mem_read,
  output logic       memory_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch_control,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_operation,
  output logic       register_write,
  output logic       register_destination,
  output logic       memory_to_register,
  output logic       instr_done,
  output logic       illegal_opcode
);

  // Per-state control table; everything not named for a state stays 0.
  always_comb begin
    mem_read             = 1'b0;
    memory_write         = 1'b0;
    iord                 = 1'b0;
    ir_write             = 1'b0;
    pc_write             = 1'b0;
    branch_control       = 1'b0;
    pc_source            = PCSRC_ALU;
    alu_src_a            = 1'b0;
    alu_src_b            = ALUB_REG_B;
    alu_operation        = ALUOP_ADD;
    register_write       = 1'b0;
    register_destination = 1'b0;
    memory_to_register   = 1'b0;
    instr_done           = 1'b0;
    illegal_opcode       = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b      = ALUB_IMM_SH2;
        illegal_opcode = ~is_supported(opcode_input);
      end
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      ST_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_MEM_WB: begin
        register_write     = 1'b1;
        memory_to_register = 1'b1;
        instr_done         = 1'b1;
      end
      ST_MEM_WRITE: begin
        memory_write = 1'b1;
        iord         = 1'b1;
        instr_done   = mem_ready;
      end
      ST_R_EXEC: begin
        alu_src_a     = 1'b1;
        alu_operation = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        register_write       = 1'b1;
        register_destination = 1'b1;
        instr_done           = 1'b1;
      end
      ST_ADDI_WB: begin
        register_write = 1'b1;
        instr_done     = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a      = 1'b1;
        alu_operation  = ALUOP_SUB;
        branch_control = 1'b1;
        pc_source      = PCSRC_ALUOUT;
        instr_done     = 1'b1;
      end
      ST_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Moore sequencer for the multicycle MIPS-subset datapath. Holds
//            the state register and next-state logic; control decode lives in
//            multicycle_control_outputs.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset_n,
  multicycle_control_if.master        bus
);

  state_t r_state;
  state_t w_next_state;

  // State register; reset drops straight to IDLE so no enable survives it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Next state: memory states hold until mem_ready, opcode read in DECODE/MEM_ADDR.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:      w_next_state = ST_FETCH;
      ST_FETCH:     if (bus.mem_ready) w_next_state = ST_DECODE;
      ST_DECODE:    w_next_state = decode_next(bus.opcode_input);
      ST_MEM_ADDR:  w_next_state = (bus.opcode_input == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (bus.mem_ready) w_next_state = ST_MEM_WB;
      ST_MEM_WRITE: if (bus.mem_ready) w_next_state = ST_FETCH;
      ST_R_EXEC:    w_next_state = ST_R_WB;
      ST_ADDI_EXEC: w_next_state = ST_ADDI_WB;
      ST_MEM_WB, ST_R_WB, ST_ADDI_WB, ST_BRANCH, ST_JUMP:
                    w_next_state = ST_FETCH;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  multicycle_control_outputs u_outputs (
    .state                (r_state),
    .mem_ready            (bus.mem_ready),
    .opcode_input         (bus.opcode_input),
    .mem_read             (bus.mem_read),
    .memory_write         (bus.memory_write),
    .iord                 (bus.iord),
    .ir_write             (bus.ir_write),
    .pc_write             (bus.pc_write),
    .branch_control       (bus.branch_control),
    .pc_source            (bus.pc_source),
    .alu_src_a            (bus.alu_src_a),
    .alu_src_b            (bus.alu_src_b),
    .alu_operation        (bus.alu_operation),
    .register_write       (bus.register_write),
    .register_destination (bus.register_destination),
    .memory_to_register   (bus.memory_to_register),
    .instr_done           (bus.instr_done),
    .illegal_opcode       (bus.illegal_opcode)
  );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Self-checking bench for multicycle_control. Each instruction is
//            expanded into a per-cycle list of expected control words with
//            its memory wait cycles, then played against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  typedef struct packed {
    logic       mem_read;
    logic       memory_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch_control;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_operation;
    logic       register_write;
    logic       register_destination;
    logic       memory_to_register;
    logic       instr_done;
    logic       illegal_opcode;
  } ctl_t;

  typedef struct {
    ctl_t       e;
    logic       mr;
    logic [5:0] op;
  } step_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  step_t q[$];

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic ctl_t sample();
    ctl_t c;
    c.mem_read             = bus.mem_read;
    c.memory_write         = bus.memory_write;
    c.iord                 = bus.iord;
    c.ir_write             = bus.ir_write;
    c.pc_write             = bus.pc_write;
    c.branch_control       = bus.branch_control;
    c.pc_source            = bus.pc_source;
    c.alu_src_a            = bus.alu_src_a;
    c.alu_src_b            = bus.alu_src_b;
    c.alu_operation        = bus.alu_operation;
    c.register_write       = bus.register_write;
    c.register_destination = bus.register_destination;
    c.memory_to_register   = bus.memory_to_register;
    c.instr_done           = bus.instr_done;
    c.illegal_opcode       = bus.illegal_opcode;
    return c;
  endfunction

  function automatic logic legal(input logic [5:0] v);
    return v inside {6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010};
  endfunction

  function automatic logic [5:0] rand_illegal();
    logic [5:0] v;
    do v = 6'($urandom_range(0, 63)); while (legal(v));
    return v;
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rmr();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input ctl_t e, input logic mr, input logic [5:0] op);
    step_t s;
    s.e = e; s.mr = mr; s.op = op;
    q.push_back(s);
  endtask

  // Expand one instruction: fw wait cycles in FETCH, mw in its memory access.
  task automatic build_instr(input logic [5:0] op, input int fw, input int mw);
    ctl_t e;
    for (int i = 0; i < fw; i++) begin
      e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01;
      push(e, 1'b0, rop());
    end
    e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(e, 1'b1, rop());
    e = '0; e.alu_src_b = 2'b11; e.illegal_opcode = !legal(op);
    push(e, rmr(), op);
    if (op == 6'b000000) begin
      e = '0; e.alu_src_a = 1'b1; e.alu_operation = 2'b10; push(e, rmr(), rop());
      e = '0; e.register_write = 1'b1; e.register_destination = 1'b1; e.instr_done = 1'b1;
      push(e, rmr(), rop());
    end else if (op == 6'b100011 || op == 6'b101011) begin
      e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; push(e, rmr(), op);
      if (op == 6'b100011) begin
        e = '0; e.mem_read = 1'b1; e.iord = 1'b1;
        for (int i = 0; i < mw; i++) push(e, 1'b0, rop());
        push(e, 1'b1, rop());
        e = '0; e.register_write = 1'b1; e.memory_to_register = 1'b1; e.instr_done = 1'b1;
        push(e, rmr(), rop());
      end else begin
        e = '0; e.memory_write = 1'b1; e.iord = 1'b1;
        for (int i = 0; i < mw; i++) push(e, 1'b0, rop());
        e.instr_done = 1'b1;
        push(e, 1'b1, rop());
      end
    end else if (op == 6'b001000) begin
      e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; push(e, rmr(), rop());
      e = '0; e.register_write = 1'b1; e.instr_done = 1'b1; push(e, rmr(), rop());
    end else if (op == 6'b000100) begin
      e = '0; e.alu_src_a = 1'b1; e.alu_operation = 2'b01; e.branch_control = 1'b1;
      e.pc_source = 2'b01; e.instr_done = 1'b1; push(e, rmr(), rop());
    end else if (op == 6'b000010) begin
      e = '0; e.pc_write = 1'b1; e.pc_source = 2'b10; e.instr_done = 1'b1;
      push(e, rmr(), rop());
    end
  endtask

  // Drive the queued cycles and compare every cycle's control word.
  task automatic play(output int first_done, output int ndone, output int nill,
                      output int niord, output int nmw);
    step_t s;
    ctl_t  got;
    int    idx;
    first_done = -1; ndone = 0; nill = 0; niord = 0; nmw = 0; idx = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      bus.mem_ready = s.mr;
      bus.opcode_input = s.op;
      #1;
      got = sample();
      checks++;
      if (got !== s.e) begin
        errors++;
        $display("FAIL cycle_%0d controls: got %h expected %h (op %b mr %b)",
                 idx, got, s.e, s.op, s.mr);
      end
      if (got.instr_done) begin
        ndone++;
        if (first_done < 0) first_done = idx;
      end
      if (got.illegal_opcode) nill++;
      if (got.iord) niord++;
      if (got.memory_write) nmw++;
      idx++;
    end
  endtask

  task automatic test_reset();
    bus.mem_ready = 1'b1;
    bus.opcode_input = 6'b000000;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (sample() !== ctl_t'(0)) begin
      errors++; $display("FAIL reset_async: got %h expected 0", sample());
    end
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if (sample() !== ctl_t'(0)) begin
        errors++; $display("FAIL reset_held: got %h expected 0", sample());
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (sample() !== ctl_t'(0)) begin
      errors++; $display("FAIL reset_idle_cycle: got %h expected 0", sample());
    end
  endtask

  task automatic test_rtype();
    int fd, nd, ni, nio, nmw;
    build_instr(6'b000000, 0, 0);
    play(fd, nd, ni, nio, nmw);
    checks++;
    if (fd + 2 != 5) begin
      errors++; $display("FAIL rtype_done_cycle: got %0d expected 5", fd + 2);
    end
  endtask

  task automatic test_lw_wait();
    int fd, nd, ni, nio, nmw;
    build_instr(6'b100011, 0, 2);
    play(fd, nd, ni, nio, nmw);
    checks++;
    if (fd + 1 != 7 || nio != 3) begin
      errors++; $display("FAIL lw_wait: got len %0d iord %0d expected len 7 iord 3", fd + 1, nio);
    end
  endtask

  task automatic test_sw();
    int fd, nd, ni, nio, nmw;
    build_instr(6'b101011, 0, 0);
    play(fd, nd, ni, nio, nmw);
    checks++;
    if (fd + 1 != 4 || nmw != 1) begin
      errors++; $display("FAIL sw: got len %0d mw %0d expected len 4 mw 1", fd + 1, nmw);
    end
  endtask

  task automatic test_branch_jump();
    int fd, nd, ni, nio, nmw;
    build_instr(6'b000100, 0, 0);
    play(fd, nd, ni, nio, nmw);
    checks++;
    if (fd + 1 != 3) begin
      errors++; $display("FAIL beq_len: got %0d expected 3", fd + 1);
    end
    build_instr(6'b000010, 0, 0);
    play(fd, nd, ni, nio, nmw);
    checks++;
    if (fd + 1 != 3) begin
      errors++; $display("FAIL j_len: got %0d expected 3", fd + 1);
    end
  endtask

  task automatic test_illegal();
    int fd, nd, ni, nio, nmw;
    build_instr(6'b111111, 0, 0);
    build_instr(rand_illegal(), 1, 0);
    play(fd, nd, ni, nio, nmw);
    checks++;
    if (nd != 0 || ni != 2) begin
      errors++; $display("FAIL illegal: got done %0d illegal %0d expected done 0 illegal 2", nd, ni);
    end
  endtask

  task automatic test_random_stream();
    int fd, nd, ni, nio, nmw;
    int legal_cnt;
    int illegal_cnt;
    logic [5:0] ops [6];
    logic [5:0] op;
    int k;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b001000; ops[4] = 6'b000100; ops[5] = 6'b000010;
    legal_cnt = 0; illegal_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      k = int'($urandom_range(0, 6));
      if (k == 6) begin
        op = rand_illegal(); illegal_cnt++;
      end else begin
        op = ops[k]; legal_cnt++;
      end
      build_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
    play(fd, nd, ni, nio, nmw);
    checks++;
    if (nd != legal_cnt || ni != illegal_cnt) begin
      errors++;
      $display("FAIL random_counts: got done %0d illegal %0d expected done %0d illegal %0d",
               nd, ni, legal_cnt, illegal_cnt);
    end
  endtask

  task automatic test_reset_mid_write();
    int fd, nd, ni, nio, nmw;
    ctl_t e;
    e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(e, 1'b1, rop());
    e = '0; e.alu_src_b = 2'b11; push(e, 1'b0, 6'b101011);
    e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; push(e, 1'b0, 6'b101011);
    e = '0; e.memory_write = 1'b1; e.iord = 1'b1; push(e, 1'b0, rop());
    play(fd, nd, ni, nio, nmw);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (sample() !== ctl_t'(0)) begin
      errors++; $display("FAIL midreset_async: got %h expected 0", sample());
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (sample() !== ctl_t'(0)) begin
      errors++; $display("FAIL midreset_idle: got %h expected 0", sample());
    end
    build_instr(6'b001000, 1, 0);
    play(fd, nd, ni, nio, nmw);
    checks++;
    if (nd != 1) begin
      errors++; $display("FAIL midreset_restart: got done %0d expected 1", nd);
    end
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.opcode_input = 6'b000000;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_branch_jump();
    test_illegal();
    test_random_stream();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
